// File: rtl/uart_tx_fifo.sv
// Byte-buffered 8N1 UART transmitter (LSB first) with a circular FIFO in front of the shifter.
// Optional sticky overflow flag: define UART_TX_OVF_EN.
module uart_tx_fifo #(
  parameter int BAUD_DIV        = 620,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               data,
  input  logic                     wr_en,
  output logic                     full,
  output logic [FIFO_DEPTH_LOG2:0] count,
  output logic                     busy,
  output logic                     tx
`ifdef UART_TX_OVF_EN
  ,
  output logic                     overflow
`endif
);

  localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
  localparam int TW    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;

  localparam logic [TW-1:0]              TIMER_LOAD = TW'(BAUD_DIV - 1);
  localparam logic [TW-1:0]              TIMER_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0]              TIMER_ONE  = TW'(1);
  localparam logic [CW-1:0]              COUNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]              COUNT_ONE  = CW'(1);
  localparam logic [CW-1:0]              COUNT_FULL = CW'(DEPTH);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ZERO   = {FIFO_DEPTH_LOG2{1'b0}};
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE    = FIFO_DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic [7:0]                 mem_r [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]              count_r, count_s;
  logic                       full_r, busy_r, tx_r, tx_s;
  state_t                     state_r, state_s;
  logic [TW-1:0]              timer_r, timer_s;
  logic [7:0]                 shift_r, shift_s;
  logic [2:0]                 bit_idx_r, bit_idx_s;
  logic                       push_s, pop_s;

  // A write is taken only when the FIFO is not full at the edge, regardless of a same-edge pop.
  assign push_s = wr_en && !full_r;

  // Serialiser next-state: pops the FIFO head from IDLE or straight out of STOP for gapless frames.
  always_comb begin
    state_s   = state_r;
    timer_s   = timer_r;
    shift_s   = shift_r;
    bit_idx_s = bit_idx_r;
    tx_s      = tx_r;
    pop_s     = 1'b0;
    case (state_r)
      IDLE: begin
        tx_s = 1'b1;
        if (count_r != COUNT_ZERO) begin
          pop_s   = 1'b1;
          shift_s = mem_r[rd_ptr_r];
          tx_s    = 1'b0;
          timer_s = TIMER_LOAD;
          state_s = START;
        end else begin
          timer_s = TIMER_ZERO;
        end
      end
      START: begin
        if (timer_r == TIMER_ZERO) begin
          tx_s      = shift_r[0];
          bit_idx_s = 3'd0;
          timer_s   = TIMER_LOAD;
          state_s   = DATA;
        end else begin
          timer_s = timer_r - TIMER_ONE;
        end
      end
      DATA: begin
        if (timer_r == TIMER_ZERO) begin
          timer_s = TIMER_LOAD;
          if (bit_idx_r == 3'd7) begin
            tx_s    = 1'b1;
            state_s = STOP;
          end else begin
            shift_s   = {1'b0, shift_r[7:1]};
            tx_s      = shift_r[1];
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          timer_s = timer_r - TIMER_ONE;
        end
      end
      STOP: begin
        if (timer_r == TIMER_ZERO) begin
          if (count_r != COUNT_ZERO) begin
            pop_s   = 1'b1;
            shift_s = mem_r[rd_ptr_r];
            tx_s    = 1'b0;
            timer_s = TIMER_LOAD;
            state_s = START;
          end else begin
            state_s = IDLE;
          end
        end else begin
          timer_s = timer_r - TIMER_ONE;
        end
      end
      default: begin
        tx_s    = 1'b1;
        timer_s = TIMER_ZERO;
        state_s = IDLE;
      end
    endcase
  end

  // Occupancy follows the accepted push and the pop; simultaneous push+pop leaves it unchanged.
  always_comb begin
    count_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + COUNT_ONE;
      2'b01:   count_s = count_r - COUNT_ONE;
      default: count_s = count_r;
    endcase
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= data;
    end
  end

  // State, pointers and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      timer_r   <= TIMER_ZERO;
      shift_r   <= 8'h00;
      bit_idx_r <= 3'd0;
      tx_r      <= 1'b1;
      wr_ptr_r  <= PTR_ZERO;
      rd_ptr_r  <= PTR_ZERO;
      count_r   <= COUNT_ZERO;
      full_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      timer_r   <= timer_s;
      shift_r   <= shift_s;
      bit_idx_r <= bit_idx_s;
      tx_r      <= tx_s;
      count_r   <= count_s;
      full_r    <= (count_s == COUNT_FULL);
      busy_r    <= (state_s != IDLE) || (count_s != COUNT_ZERO);
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  assign tx    = tx_r;
  assign full  = full_r;
  assign count = count_r;
  assign busy  = busy_r;

`ifdef UART_TX_OVF_EN
  logic overflow_r;

  // Sticky record of any write attempted while full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (wr_en && full_r) begin
      overflow_r <= 1'b1;
    end
  end

  assign overflow = overflow_r;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed steps plus a random burst phase, compared each
// cycle against a frame-timeline model (queue of pending bytes + position within current frame).
module tb_uart_tx_fifo;

  localparam int B    = 4;
  localparam int LOG2 = 4;
  localparam int DEP  = 16;

  logic        clk;
  logic        reset;
  logic [7:0]  data;
  logic        wr_en;
  logic        full;
  logic [4:0]  count;
  logic        busy;
  logic        tx;
`ifdef UART_TX_OVF_EN
  logic        overflow;
`endif

  uart_tx_fifo #(.BAUD_DIV(B), .FIFO_DEPTH_LOG2(LOG2)) dut (
    .clk      (clk),
    .reset    (reset),
    .data     (data),
    .wr_en    (wr_en),
    .full     (full),
    .count    (count),
    .busy     (busy),
    .tx       (tx)
`ifdef UART_TX_OVF_EN
    ,
    .overflow (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: bytes waiting, byte on the line, cycles elapsed in the current frame.
  logic [7:0] q [$];
  logic [7:0] cur;
  bit         active;
  int         ft;
  bit         ovf_m;

  function automatic void model_reset();
    q.delete();
    active = 1'b0;
    ft     = 0;
    cur    = 8'h00;
    ovf_m  = 1'b0;
  endfunction

  function automatic void model_step(input bit wr, input logic [7:0] d);
    bit pop_ok;
    bit push_ok;
    pop_ok  = (q.size() != 0) && (!active || ft == 10*B - 1);
    push_ok = wr && (q.size() < DEP);
    if (active) begin
      ft++;
      if (ft == 10*B) active = 1'b0;
    end
    if (pop_ok) begin
      cur    = q.pop_front();
      active = 1'b1;
      ft     = 0;
    end
    if (push_ok) q.push_back(d);
    if (wr && !push_ok) ovf_m = 1'b1;
  endfunction

  function automatic logic exp_tx();
    if (!active)     return 1'b1;
    if (ft < B)      return 1'b0;
    if (ft < 9*B)    return cur[(ft - B) / B];
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("tx", {31'd0, tx}, {31'd0, exp_tx()});
    chk("count", {27'd0, count}, q.size());
    chk("busy", {31'd0, busy}, {31'd0, (active || q.size() != 0)});
    chk("full", {31'd0, full}, {31'd0, (q.size() == DEP)});
`ifdef UART_TX_OVF_EN
    chk("overflow", {31'd0, overflow}, {31'd0, ovf_m});
`endif
  endtask

  // Drive one cycle from a negedge; model the edge; check at the following negedge.
  task automatic tick(input bit wr, input logic [7:0] d);
    wr_en = wr;
    data  = wr ? d : 8'bxxxxxxxx;
    @(posedge clk);
    model_step(wr, d);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
  endtask

  task automatic push(input logic [7:0] d);
    tick(1'b1, d);
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    data  = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    reset = 1'b0;
    idle(3);

    // Single frame of 0x55
    push(8'h55);
    idle(45);

    // Three back-to-back frames
    push(8'h00);
    push(8'hFF);
    push(8'hA5);
    idle(125);

    // Fill to exactly full from an idle line
    for (int i = 0; i < 17; i++) push(8'(8'h10 + i));
    push(8'h99);
    idle(17 * 10 * B + 10);

    // Paced stream wrapping the pointers twice
    for (int i = 0; i < 40; i++) begin
      push(8'(i));
      idle(29);
    end
    idle(50);

    // Back-to-back pushes where the second lands on the pop edge
    push(8'h3C);
    push(8'hC3);
    idle(90);

    // Reset asserted during data bit 3 of 0xC3 with five more queued
    push(8'hC3);
    for (int i = 0; i < 5; i++) push(8'($urandom));
    idle(13);
    #2 reset = 1'b1;
    model_reset();
    #1 check_all();
    @(negedge clk);
    check_all();
    reset = 1'b0;
    push(8'h7E);
    idle(45);

    // Random bursts: fills, drops, push on pop edges, wrap-around
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 99) < 30, 8'($urandom));
    end
    idle(DEP * 10 * B + 60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
